// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared state encoding for the add_seq_ctrl operand accumulator.
// Build option: ADD_SEQ_DRAIN_EN adds a DRAIN state and widens the state to 3 bits.
package add_seq_pkg;
`ifdef ADD_SEQ_DRAIN_EN
    localparam int SW = 3;
    typedef enum logic [SW-1:0] {
        IDLE  = 3'b000,
        LOAD  = 3'b001,
        ACC   = 3'b010,
        DONE  = 3'b011,
        DRAIN = 3'b100
    } state_t;
`else
    localparam int SW = 2;
    typedef enum logic [SW-1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        ACC  = 2'b10,
        DONE = 2'b11
    } state_t;
`endif
endpackage

// File: rtl/add_core.sv
// add_core: combinational WIDTH-bit carry-lookahead adder.
// Ports: a, b (WIDTH) operands; cin carry in; s (WIDTH) sum; cout carry out.
module add_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);
    logic [WIDTH-1:0] g, p;
    logic [WIDTH:0]   c;
    // Each carry is expanded from g/p/cin alone, so no carry waits on its neighbour.
    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = cin;
            for (int j = 0; j <= i; j++) c[i+1] = g[j] | (p[j] & c[i+1]);
        end
    end
    assign s    = p ^ c[WIDTH-1:0];
    assign cout = c[WIDTH];
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: accumulates a valid/ready operand stream, keeping the last non-overflowing sum.
// Ports: clk, rst (sync active-high); start begins a job in IDLE; op_valid/op_data/op_last
// with op_ready form the operand handshake; busy is high outside IDLE; done pulses one cycle
// with sum, count (operands in sum) and overflow (job ended on a carry-out).
// Build option: ADD_SEQ_DRAIN_EN discards the rest of an overflowed job before done.
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter  int WIDTH   = 4,
    parameter  int MAX_OPS = 4,
    localparam int CW      = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_valid,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_last,
    output logic             op_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic [CW-1:0]    count,
    output logic             overflow
);
    state_t           state, nstate;
    logic [WIDTH-1:0] sum_d, add_s;
    logic [CW-1:0]    count_d;
    logic             ovf_d, add_c, accept;
`ifdef ADD_SEQ_DRAIN_EN
    logic [CW-1:0]    beats_q, beats_d;
`endif

    add_core #(.WIDTH(WIDTH)) u_core (
        .a    (sum),
        .b    (op_data),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_c)
    );

    always_comb begin
        op_ready = (state == LOAD) || (state == ACC)
`ifdef ADD_SEQ_DRAIN_EN
                   || (state == DRAIN)
`endif
                   ;
        busy     = state != IDLE;
        done     = state == DONE;
        accept   = op_valid && op_ready;
    end

    always_comb begin
        nstate  = state;
        sum_d   = sum;
        count_d = count;
        ovf_d   = overflow;
`ifdef ADD_SEQ_DRAIN_EN
        beats_d = accept ? beats_q + CW'(1) : beats_q;
`endif
        case (state)
            IDLE: if (start) begin
                nstate  = LOAD;
                sum_d   = '0;
                count_d = '0;
                ovf_d   = 1'b0;
`ifdef ADD_SEQ_DRAIN_EN
                beats_d = '0;
`endif
            end
            LOAD: if (accept) begin
                sum_d   = op_data;
                count_d = CW'(1);
                nstate  = (op_last || MAX_OPS == 1) ? DONE : ACC;
            end
            ACC: if (accept) begin
                if (add_c) begin
                    ovf_d  = 1'b1;
`ifdef ADD_SEQ_DRAIN_EN
                    // Skip DRAIN when the overflowing beat already closes the job.
                    nstate = (op_last || beats_q + CW'(1) == CW'(MAX_OPS)) ? DONE : DRAIN;
`else
                    nstate = DONE;
`endif
                end else begin
                    sum_d   = add_s;
                    count_d = count + CW'(1);
                    nstate  = (op_last || count + CW'(1) == CW'(MAX_OPS)) ? DONE : ACC;
                end
            end
`ifdef ADD_SEQ_DRAIN_EN
            DRAIN: if (accept && (op_last || beats_q + CW'(1) == CW'(MAX_OPS))) nstate = DONE;
`endif
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sum      <= '0;
            count    <= '0;
            overflow <= 1'b0;
`ifdef ADD_SEQ_DRAIN_EN
            beats_q  <= '0;
`endif
        end else begin
            state    <= nstate;
            sum      <= sum_d;
            count    <= count_d;
            overflow <= ovf_d;
`ifdef ADD_SEQ_DRAIN_EN
            beats_q  <= beats_d;
`endif
        end
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed self-checking bench for add_seq_ctrl (WIDTH=4, MAX_OPS=4).
module tb_add_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst, start, op_valid, op_last;
    logic [3:0] op_data;
    logic       op_ready, busy, done, overflow;
    logic [3:0] sum;
    logic [2:0] count;
    int         checks = 0;
    int         errors = 0;

    add_seq_ctrl #(.WIDTH(4), .MAX_OPS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_valid (op_valid),
        .op_data  (op_data),
        .op_last  (op_last),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .count    (count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic kick();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [3:0] d, input logic l);
        op_valid = 1'b1;
        op_data  = d;
        op_last  = l;
        chk("ready_for_beat", op_ready, 1);
        @(negedge clk);
        op_valid = 1'b0;
        op_last  = 1'b0;
    endtask

    task automatic result(input string tag, input logic [3:0] s, input logic [2:0] c, input logic o);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_ready"}, op_ready, 0);
        chk({tag, "_sum"}, sum, s);
        chk({tag, "_count"}, count, c);
        chk({tag, "_ovf"}, overflow, o);
        @(negedge clk);
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_hold"}, sum, s);
    endtask

    initial begin
        logic [5:0] vpat;
        logic [3:0] vdat [3];
        int k;
        rst = 1'b1; start = 1'b0; op_valid = 1'b0; op_data = '0; op_last = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", op_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        @(negedge clk);

        kick();
        chk("t1_busy", busy, 1);
        beat(4'd3, 1'b0); beat(4'd4, 1'b0); beat(4'd5, 1'b0);
        chk("t1_pre_done", done, 0);
        beat(4'd2, 1'b1);
        result("t1", 4'd14, 3'd4, 1'b0);

        kick();
        beat(4'd9, 1'b0); beat(4'd5, 1'b0); beat(4'd3, 1'b0);
`ifdef ADD_SEQ_DRAIN_EN
        chk("t2_drain_ready", op_ready, 1);
        beat(4'd0, 1'b1);
`endif
        result("t2", 4'd14, 3'd2, 1'b1);

        kick();
        chk("t3_clr_ovf", overflow, 0);
        chk("t3_clr_sum", sum, 0);
        chk("t3_clr_count", count, 0);
        beat(4'd7, 1'b1);
        result("t3a", 4'd7, 3'd1, 1'b0);
        kick();
        beat(4'd15, 1'b0); beat(4'd0, 1'b1);
        result("t3b", 4'd15, 3'd2, 1'b0);

        kick();
        vpat = 6'b101001;
        vdat = '{4'd1, 4'd2, 4'd3};
        k = 0;
        for (int i = 0; i < 6; i++) begin
            op_valid = vpat[i];
            op_data  = vpat[i] ? vdat[k] : 4'd15;
            op_last  = vpat[i] ? (k == 2) : 1'b1;
            if (vpat[i]) k++;
            @(negedge clk);
        end
        op_valid = 1'b0; op_last = 1'b0;
        result("t4", 4'd6, 3'd3, 1'b0);

        kick();
        beat(4'd1, 1'b0); beat(4'd2, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5_start_ign_busy", busy, 1);
        chk("t5_start_ign_sum", sum, 3);
        chk("t5_start_ign_count", count, 2);
        rst = 1'b1; op_valid = 1'b1; op_data = 4'd4;
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", op_ready, 0);
        chk("t5_rst_sum", sum, 0);
        chk("t5_rst_count", count, 0);
        @(negedge clk);
        chk("t5_stay_idle", busy, 0);

`ifdef ADD_SEQ_DRAIN_EN
        kick();
        beat(4'd9, 1'b0); beat(4'd8, 1'b0);
        chk("t6_ovf_flag", overflow, 1);
        chk("t6_no_done", done, 0);
        beat(4'd1, 1'b0); beat(4'd1, 1'b1);
        result("t6", 4'd9, 3'd1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
